qar_timer_irq: RTL and testbench

//  Memory-mapped machine timer feeding the qar_core irq_timer input. Holds a 64-bit

---
 rtl/qar_timer_irq.sv | 170 +++++++++++++++++
 tb/tb_qar_timer_irq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qar_timer_irq.sv
// qar_timer_irq -- memory-mapped machine timer for the qar_core irq_timer input.
//   Holds a 64-bit free-running mtime and a 64-bit mtimecmp. A rising compare match
//   sets a sticky pending flag. The core's ack edge or a STATUS W1C write clears it.
//   AUTO_RELOAD advances mtimecmp by PERIOD on each ack, which gives periodic ticks.
// Ports:
//   clk, rst                     core clock, synchronous active-high reset
//   mem_valid/we/addr/wdata      bus request (block already selected by interconnect)
//   mem_ready, mem_rdata         one-cycle completion pulse and read data
//   irq_timer                    registered level interrupt (= pending)
//   irq_timer_ack                core acknowledge, rising edge consumes the interrupt
// Register map (byte offsets): 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 CMP_LO, 0x0C CMP_HI,
//   0x10 CTRL {AUTO_RELOAD, EN}, 0x14 PERIOD, 0x18 STATUS {PENDING (W1C)}
module qar_timer_irq #(
  parameter int unsigned PRESCALE  = 16,
  parameter int unsigned ADDR_BITS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        irq_timer,
  input  logic        irq_timer_ack
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [ADDR_BITS-3:0] {
    REG_MTIME_LO = 0,
    REG_MTIME_HI = 1,
    REG_CMP_LO   = 2,
    REG_CMP_HI   = 3,
    REG_CTRL     = 4,
    REG_PERIOD   = 5,
    REG_STATUS   = 6
  } reg_e;

  logic [63:0]   r_mtime;
  logic [63:0]   r_cmp;
  logic [31:0]   r_period;
  logic [31:0]   r_shadow_hi;
  logic          r_en;
  logic          r_auto;
  logic          r_pending;
  logic          r_ready;
  logic [31:0]   r_rdata;
  logic [PW-1:0] r_presc;
  logic          r_ack_q;
  logic          r_match_q;

  reg_e          w_idx;
  logic          w_accept;
  logic          w_wr;
  logic          w_rd;
  logic          w_tick;
  logic          w_match;
  logic          w_ack_rise;
  logic          w_w1c;
  logic [31:0]   w_rdata;
  logic          w_unused_addr;

  assign w_idx         = reg_e'(mem_addr[ADDR_BITS-1:2]);
  assign w_unused_addr = ^{mem_addr[31:ADDR_BITS], mem_addr[1:0]};
  assign w_accept      = mem_valid && !r_ready;
  assign w_wr          = w_accept && mem_we;
  assign w_rd          = w_accept && !mem_we;
  assign w_tick        = r_en && (r_presc == PW'(PRESCALE - 1));
  assign w_match       = r_en && (r_mtime >= r_cmp);
  assign w_ack_rise    = irq_timer_ack && !r_ack_q;
  assign w_w1c         = w_wr && (w_idx == REG_STATUS) && mem_wdata[0];

  // Read mux; MTIME_HI returns the shadow captured by the last MTIME_LO read.
  always_comb begin
    w_rdata = '0;
    case (w_idx)
      REG_MTIME_LO: w_rdata = r_mtime[31:0];
      REG_MTIME_HI: w_rdata = r_shadow_hi;
      REG_CMP_LO:   w_rdata = r_cmp[31:0];
      REG_CMP_HI:   w_rdata = r_cmp[63:32];
      REG_CTRL:     w_rdata = {30'b0, r_auto, r_en};
      REG_PERIOD:   w_rdata = r_period;
      REG_STATUS:   w_rdata = {31'b0, r_pending};
      default:      w_rdata = '0;
    endcase
  end

  // Bus handshake: ready pulses for exactly one cycle after accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready     <= 1'b0;
      r_rdata     <= '0;
      r_shadow_hi <= '0;
    end else begin
      r_ready <= w_accept;
      r_rdata <= w_rd ? w_rdata : '0;
      if (w_rd && (w_idx == REG_MTIME_LO))
        r_shadow_hi <= r_mtime[63:32];
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en     <= 1'b0;
      r_auto   <= 1'b0;
      r_period <= '0;
    end else if (w_wr) begin
      if (w_idx == REG_CTRL) begin
        r_en   <= mem_wdata[0];
        r_auto <= mem_wdata[1];
      end
      if (w_idx == REG_PERIOD)
        r_period <= mem_wdata;
    end
  end

  // Prescaler and mtime; a software write replaces the tick increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_mtime <= '0;
    end else begin
      if (r_en)
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_wr && (w_idx == REG_MTIME_LO))
        r_mtime <= {r_mtime[63:32], mem_wdata};
      else if (w_wr && (w_idx == REG_MTIME_HI))
        r_mtime <= {mem_wdata, r_mtime[31:0]};
      else if (w_tick)
        r_mtime <= r_mtime + 64'd1;
    end
  end

  // Compare register; a software write suppresses the ack-driven reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmp <= '1;
    end else if (w_wr && (w_idx == REG_CMP_LO)) begin
      r_cmp <= {r_cmp[63:32], mem_wdata};
    end else if (w_wr && (w_idx == REG_CMP_HI)) begin
      r_cmp <= {mem_wdata, r_cmp[31:0]};
    end else if (w_ack_rise && r_auto) begin
      r_cmp <= r_cmp + {32'b0, r_period};
    end
  end

  // Pending: a rising match takes priority over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 1'b0;
      r_ack_q   <= 1'b0;
      r_match_q <= 1'b0;
    end else begin
      r_ack_q   <= irq_timer_ack;
      r_match_q <= w_match;
      if (w_match && !r_match_q)
        r_pending <= 1'b1;
      else if (w_ack_rise || w_w1c)
        r_pending <= 1'b0;
    end
  end

  assign mem_ready = r_ready;
  assign mem_rdata = r_rdata;
  assign irq_timer = r_pending;

endmodule

// File: tb/tb_qar_timer_irq.sv
module tb_qar_timer_irq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        irq_timer;
  logic        irq_timer_ack = 1'b0;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned rises = 0;
  logic        irq_prev = 1'b0;

  qar_timer_irq #(.PRESCALE(4), .ADDR_BITS(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_valid     (mem_valid),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .irq_timer     (irq_timer),
    .irq_timer_ack (irq_timer_ack)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (irq_timer && !irq_prev) rises++;
    irq_prev <= irq_timer;
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd);
    int unsigned n;
    @(negedge clk);
    mem_valid = 1'b1;
    mem_we    = we;
    mem_addr  = addr;
    mem_wdata = wd;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!mem_ready && n < 8);
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    checks++;
    if (!mem_ready) begin
      errors++;
      $display("FAIL bus_timeout addr %h: ready=%b expected 1", addr, mem_ready);
    end
    rd = mem_rdata;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] d;
    bus(1'b1, addr, wd, d);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus(1'b0, addr, 32'h0, d);
    chk(name, d, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Wait for irq_timer high; returns posedges elapsed (0 if bound expired, flagged).
  task automatic wait_irq(input int unsigned limit, output int unsigned n);
    n = 0;
    while (!irq_timer && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!irq_timer) begin
      checks++;
      errors++;
      $display("FAIL irq_timeout: irq_timer=%b expected 1 within %0d cycles", irq_timer, limit);
      n = 0;
    end
  endtask

  task automatic ack_pulse();
    irq_timer_ack = 1'b1;
    @(posedge clk);
    #1 irq_timer_ack = 1'b0;
  endtask

  task automatic chk_reset_regs(input string tag);
    rd_chk({tag, "_mtime_lo"}, 32'h00, 32'h0);
    rd_chk({tag, "_mtime_hi"}, 32'h04, 32'h0);
    rd_chk({tag, "_cmp_lo"},   32'h08, 32'hFFFF_FFFF);
    rd_chk({tag, "_cmp_hi"},   32'h0C, 32'hFFFF_FFFF);
    rd_chk({tag, "_ctrl"},     32'h10, 32'h0);
    rd_chk({tag, "_period"},   32'h14, 32'h0);
    rd_chk({tag, "_status"},   32'h18, 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    int unsigned n;
    int unsigned r0;

    // Register access vectors with timer disabled (mtime frozen).
    tbl.push_back('{1'b0, 32'h00, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b0, 32'h04, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b0, 32'h08, 32'h0, 32'hFFFF_FFFF});
    tbl.push_back('{1'b0, 32'h0C, 32'h0, 32'hFFFF_FFFF});
    tbl.push_back('{1'b0, 32'h10, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b0, 32'h14, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b0, 32'h18, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b0, 32'h1C, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b1, 32'h14, 32'hDEAD_BEEF, 32'h0});
    tbl.push_back('{1'b0, 32'h14, 32'h0, 32'hDEAD_BEEF});
    tbl.push_back('{1'b1, 32'h10, 32'h0000_0002, 32'h0});
    tbl.push_back('{1'b0, 32'h10, 32'h0, 32'h0000_0002});
    tbl.push_back('{1'b1, 32'h1C, 32'h0000_0005, 32'h0});
    tbl.push_back('{1'b0, 32'h1C, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b1, 32'h08, 32'h0000_0055, 32'h0});
    tbl.push_back('{1'b0, 32'h08, 32'h0, 32'h0000_0055});
    tbl.push_back('{1'b1, 32'h00, 32'h0000_0007, 32'h0});
    tbl.push_back('{1'b1, 32'h04, 32'h0000_0009, 32'h0});
    tbl.push_back('{1'b0, 32'h04, 32'h0, 32'h0000_0000});
    tbl.push_back('{1'b0, 32'h00, 32'h0, 32'h0000_0007});
    tbl.push_back('{1'b0, 32'h04, 32'h0, 32'h0000_0009});

    // 1. Reset state, table of accesses, ready pulse width.
    do_reset();
    chk("reset_irq", {31'b0, irq_timer}, 32'h0);
    chk("reset_ready", {31'b0, mem_ready}, 32'h0);
    foreach (tbl[i]) begin
      bus(tbl[i].we, tbl[i].addr, tbl[i].wdata, d);
      if (!tbl[i].we) chk($sformatf("vec%0d_rd_%0h", i, tbl[i].addr), d, tbl[i].exp);
    end
    @(posedge clk);
    #1 chk("ready_one_cycle", {31'b0, mem_ready}, 32'h0);

    // 2. Single compare match, ack clears and stays cleared.
    do_reset();
    wr(32'h0C, 32'h0);
    wr(32'h08, 32'd10);
    chk("t2_irq_before_en", {31'b0, irq_timer}, 32'h0);
    wr(32'h10, 32'h1);
    wait_irq(200, n);
    chk("t2_irq_latency", n, 32'd41);
    irq_timer_ack = 1'b1;
    @(posedge clk);
    #1 chk("t2_irq_after_ack", {31'b0, irq_timer}, 32'h0);
    repeat (3) @(posedge clk);
    #1 irq_timer_ack = 1'b0;
    r0 = rises;
    repeat (20) @(posedge clk);
    #1 chk("t2_irq_stays_low", {31'b0, irq_timer}, 32'h0);
    chk("t2_no_new_rise", rises - r0, 32'd0);

    // 3. Auto-reload periodic ticks.
    do_reset();
    r0 = rises;
    wr(32'h14, 32'd5);
    wr(32'h0C, 32'h0);
    wr(32'h08, 32'd10);
    wr(32'h10, 32'h3);
    wait_irq(400, n);
    ack_pulse();
    chk("t3_irq_low_ack1", {31'b0, irq_timer}, 32'h0);
    rd_chk("t3_cmp_after_ack1", 32'h08, 32'd15);
    wait_irq(400, n);
    ack_pulse();
    rd_chk("t3_cmp_after_ack2", 32'h08, 32'd20);
    rd_chk("t3_cmp_hi", 32'h0C, 32'd0);
    chk("t3_rise_count", rises - r0, 32'd2);

    // 4. 64-bit wrap and coherent MTIME_LO/HI reads.
    do_reset();
    wr(32'h00, 32'hFFFF_FFFE);
    wr(32'h04, 32'hFFFF_FFFF);
    wr(32'h10, 32'h1);               // accept edge A; ticks at A+4, A+8, A+12
    repeat (6) @(posedge clk);
    rd_chk("t4_lo_before_wrap", 32'h00, 32'hFFFF_FFFF);   // accepted at A+7
    rd_chk("t4_hi_shadow", 32'h04, 32'hFFFF_FFFF);        // accepted at A+9, after wrap
    rd_chk("t4_lo_after_wrap", 32'h00, 32'h0);            // accepted at A+11
    rd_chk("t4_hi_after_wrap", 32'h04, 32'h0);

    // 5. Rising match coincident with ack edge; STATUS W1C.
    do_reset();
    wr(32'h0C, 32'h0);
    wr(32'h08, 32'd100);
    wr(32'h10, 32'h1);
    wr(32'h08, 32'd0);
    repeat (2) @(posedge clk);
    #1 chk("t5_first_pending", {31'b0, irq_timer}, 32'h1);
    ack_pulse();
    chk("t5_ack_clears", {31'b0, irq_timer}, 32'h0);
    wr(32'h08, 32'd100);
    wr(32'h08, 32'd0);
    irq_timer_ack = 1'b1;
    @(posedge clk);
    #1 irq_timer_ack = 1'b0;
    chk("t5_set_wins", {31'b0, irq_timer}, 32'h1);
    wr(32'h18, 32'h0);
    chk("t5_status_w0", {31'b0, irq_timer}, 32'h1);
    rd_chk("t5_status_rd1", 32'h18, 32'h1);
    wr(32'h18, 32'h1);
    chk("t5_status_w1c", {31'b0, irq_timer}, 32'h0);
    rd_chk("t5_status_rd0", 32'h18, 32'h0);

    // 6. Reset on the accept edge of a read drops it.
    wr(32'h14, 32'd7);
    wr(32'h10, 32'h3);
    wr(32'h08, 32'd0);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_we    = 1'b0;
    mem_addr  = 32'h14;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    chk("t6_ready_dropped", {31'b0, mem_ready}, 32'h0);
    chk("t6_rdata_zero", mem_rdata, 32'h0);
    chk("t6_irq_zero", {31'b0, irq_timer}, 32'h0);
    rst = 1'b0;
    chk_reset_regs("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
